// File: rtl/gpio_cfg_sequencer_if.sv
// Host register-bus handshake between the host (master) and the GPIO config sequencer (slave).
// Requests are levels held until the one-cycle host_ack.
interface gpio_cfg_sequencer_if #(
  parameter int AddrWidth = 16,
  parameter int BusWidth  = 32
);
  logic                 host_write;
  logic                 host_read;
  logic [AddrWidth-3:0] host_address;
  logic [BusWidth-1:0]  host_data_in;
  logic                 host_ack;
  logic [BusWidth-1:0]  host_data_out;

  modport master (
    output host_write,
    output host_read,
    output host_address,
    output host_data_in,
    input  host_ack,
    input  host_data_out
  );

  modport slave (
    input  host_write,
    input  host_read,
    input  host_address,
    input  host_data_in,
    output host_ack,
    output host_data_out
  );
endinterface

// File: rtl/gpio_cfg_sequencer.sv
// Replays a (word_addr, data) config table into the GPIO decoder after reset or on start,
// otherwise forwards host reads/writes one at a time with single-cycle strobes and held bus.
module gpio_cfg_sequencer #(
  parameter int AddrWidth    = 16,
  parameter int BusWidth     = 32,
  parameter int TblAddrWidth = 6,
  parameter int NumEntries   = 36,
  parameter int HoldCycles   = 4,
  parameter int ReadLatency  = 3,
  parameter int LoadOnReset  = 1
) (
  input  logic                            reg_clk,
  input  logic                            reset_reg,
  input  logic                            start,
  output logic [TblAddrWidth-1:0]         tbl_addr,
  input  logic [AddrWidth-2+BusWidth-1:0] tbl_data,
  gpio_cfg_sequencer_if.slave             host,
  output logic                            write_reg,
  output logic                            read_reg,
  output logic [AddrWidth-3:0]            busaddress,
  output logic [BusWidth-1:0]             busdata_in,
  input  logic [BusWidth-1:0]             busdata_out,
  output logic                            busy,
  output logic                            load_done
);

  localparam int WA       = AddrWidth - 2;
  localparam int HOLD_EFF = (HoldCycles < 3) ? 3 : HoldCycles;
  localparam int RD_WAIT  = (ReadLatency < 1) ? 1 : ReadLatency;
  localparam int CNT_W    = 8;
  localparam int GAP_MIN  = HOLD_EFF - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_FETCH,
    S_LD_ISSUE,
    S_LD_HOLD,
    S_H_WR,
    S_H_RD,
    S_H_HOLD,
    S_H_RDWAIT
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [TblAddrWidth-1:0] r_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        r_gap;
  logic                    r_pend_load;
  logic                    r_ack;
  logic [BusWidth-1:0]     r_hdo;
  logic [WA-1:0]           r_addr;
  logic [BusWidth-1:0]     r_data;

  logic [WA-1:0]           w_tbl_word;
  logic [BusWidth-1:0]     w_tbl_val;
  logic                    w_term;
  logic                    w_cnt_zero;
  logic                    w_last;
  logic                    w_gap_ok;

  assign w_tbl_word = tbl_data[WA+BusWidth-1:BusWidth];
  assign w_tbl_val  = tbl_data[BusWidth-1:0];
  assign w_term     = &w_tbl_word;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_last     = (r_idx == TblAddrWidth'(NumEntries - 1));
  // r_gap counts strobe-low cycles; IDLE only launches once a full hold gap has elapsed.
  assign w_gap_ok   = (r_gap == CNT_W'(GAP_MIN));

  always_ff @(posedge reg_clk) begin
    if (reset_reg) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_gap_ok) begin
          if (start || r_pend_load) begin
            w_state_next = S_LD_FETCH;
          end else if (!r_ack && host.host_write) begin
            w_state_next = S_H_WR;
          end else if (!r_ack && host.host_read) begin
            w_state_next = S_H_RD;
          end
        end
      end
      S_LD_FETCH: w_state_next = S_LD_ISSUE;
      S_LD_ISSUE: w_state_next = w_term ? S_IDLE : S_LD_HOLD;
      S_LD_HOLD: begin
        if (w_cnt_zero) begin
          w_state_next = w_last ? S_IDLE : S_LD_FETCH;
        end
      end
      S_H_WR:     w_state_next = S_H_HOLD;
      S_H_RD:     w_state_next = S_H_RDWAIT;
      S_H_HOLD:   if (w_cnt_zero) w_state_next = S_IDLE;
      S_H_RDWAIT: if (w_cnt_zero) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Table data only arrives during LD_ISSUE, so that cycle drives the bus straight from it.
  always_comb begin
    tbl_addr           = '0;
    write_reg          = 1'b0;
    read_reg           = 1'b0;
    busaddress         = r_addr;
    busdata_in         = r_data;
    busy               = (r_state != S_IDLE);
    load_done          = 1'b0;
    host.host_ack      = r_ack;
    host.host_data_out = r_hdo;
    unique case (r_state)
      S_LD_FETCH: tbl_addr = r_idx;
      S_LD_ISSUE: begin
        if (w_term) begin
          load_done = 1'b1;
        end else begin
          write_reg  = 1'b1;
          busaddress = w_tbl_word;
          busdata_in = w_tbl_val;
        end
      end
      S_LD_HOLD:  load_done = w_cnt_zero && w_last;
      S_H_WR:     write_reg = 1'b1;
      S_H_RD:     read_reg  = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge reg_clk) begin
    if (reset_reg) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_gap       <= CNT_W'(GAP_MIN);
      r_pend_load <= (LoadOnReset != 0);
      r_ack       <= 1'b0;
      r_hdo       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
    end else begin
      r_ack <= ((r_state == S_H_HOLD) || (r_state == S_H_RDWAIT)) && w_cnt_zero;

      if (r_state == S_IDLE && w_state_next == S_LD_FETCH) begin
        r_pend_load <= 1'b0;
      end

      if (write_reg || read_reg) begin
        r_gap <= '0;
      end else if (!w_gap_ok) begin
        r_gap <= r_gap + 1'b1;
      end

      if (r_state == S_LD_ISSUE || r_state == S_H_WR) begin
        r_cnt <= CNT_W'(HOLD_EFF - 1);
      end else if (r_state == S_H_RD) begin
        r_cnt <= CNT_W'(RD_WAIT - 1);
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (r_state == S_LD_ISSUE && w_term) begin
        r_idx <= '0;
      end else if (r_state == S_LD_HOLD && w_cnt_zero) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end

      if (r_state == S_IDLE && w_state_next == S_H_WR) begin
        r_addr <= host.host_address;
        r_data <= host.host_data_in;
      end else if (r_state == S_IDLE && w_state_next == S_H_RD) begin
        r_addr <= host.host_address;
      end else if (r_state == S_LD_ISSUE && !w_term) begin
        r_addr <= w_tbl_word;
        r_data <= w_tbl_val;
      end

      if (r_state == S_H_RDWAIT && w_cnt_zero) begin
        r_hdo <= busdata_out;
      end
    end
  end

endmodule

// File: tb/tb_gpio_cfg_sequencer.sv
// Scoreboard bench for gpio_cfg_sequencer: table replay, terminator, host write/read,
// host request and start during a load, and reset in the middle of a host write.
`timescale 1ns/1ps
module tb_gpio_cfg_sequencer;
  localparam int AW   = 16;
  localparam int BW   = 32;
  localparam int TAW  = 6;
  localparam int NE   = 36;
  localparam int HOLD = 4;
  localparam int RL   = 3;
  localparam int WA   = AW - 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [TAW-1:0] tbl_addr;
  logic [WA+BW-1:0] tbl_data;
  logic           write_reg, read_reg, busy, load_done;
  logic [WA-1:0]  busaddress;
  logic [BW-1:0]  busdata_in, busdata_out;

  gpio_cfg_sequencer_if #(.AddrWidth(AW), .BusWidth(BW)) hif ();

  gpio_cfg_sequencer #(
    .AddrWidth(AW), .BusWidth(BW), .TblAddrWidth(TAW), .NumEntries(NE),
    .HoldCycles(HOLD), .ReadLatency(RL), .LoadOnReset(1)
  ) dut (
    .reg_clk(clk), .reset_reg(rst), .start(start),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .host(hif),
    .write_reg(write_reg), .read_reg(read_reg),
    .busaddress(busaddress), .busdata_in(busdata_in), .busdata_out(busdata_out),
    .busy(busy), .load_done(load_done)
  );

  always #5 clk = ~clk;

  // Synchronous config table and a decoder read model returning data RL cycles after read_reg.
  logic [WA+BW-1:0] tbl_mem [0:(1<<TAW)-1];
  always @(posedge clk) tbl_data <= tbl_mem[tbl_addr];

  logic [2:0]    rd_pipe = '0;
  logic [BW-1:0] rd_value = 32'hCAFEF00D;
  always @(posedge clk) rd_pipe <= {rd_pipe[1:0], read_reg};
  assign busdata_out = rd_pipe[2] ? rd_value : 32'hDEADBEEF;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    bit            is_rd;
    logic [BW-1:0] data;
  } ack_t;

  logic [WA+BW-1:0] wq[$];
  ack_t             aq[$];
  int wr_count = 0;
  int ld_count = 0;
  int ld_cyc = 0;
  int last_wr_cyc = 0;
  int last_strobe = -100;
  logic prev_wr = 1'b0;

  // Bus monitor: pops expected writes on each write_reg and expected acks on each host_ack.
  always @(negedge clk) begin
    logic [WA+BW-1:0] ew;
    ack_t ea;
    if (rst) begin
      prev_wr = 1'b0;
      last_strobe = -100;
    end else begin
      if (write_reg || read_reg) begin
        check_val("strobe_gap", 64'((cyc - last_strobe) > HOLD), 64'd1);
        last_strobe = cyc;
      end
      if (write_reg) begin
        wr_count++;
        last_wr_cyc = cyc;
        check_val("wr_width", 64'(prev_wr), 64'd0);
        check_val("wr_queue_nonempty", 64'(wq.size() != 0), 64'd1);
        if (wq.size() != 0) begin
          ew = wq.pop_front();
          check_val("wr_addr", 64'(busaddress), 64'(ew[WA+BW-1:BW]));
          check_val("wr_data", 64'(busdata_in), 64'(ew[BW-1:0]));
        end
      end
      if (hif.host_ack) begin
        check_val("ack_queue_nonempty", 64'(aq.size() != 0), 64'd1);
        if (aq.size() != 0) begin
          ea = aq.pop_front();
          if (ea.is_rd) check_val("rd_data", 64'(hif.host_data_out), 64'(ea.data));
        end
      end
      if (load_done) begin
        ld_count++;
        ld_cyc = cyc;
      end
      prev_wr = write_reg;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_table();
    for (int i = 0; i < NE; i++) begin
      if (&tbl_mem[i][WA+BW-1:BW]) break;
      wq.push_back(tbl_mem[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ctrl"}, 64'({tbl_addr, write_reg, read_reg, hif.host_ack, busy, load_done, busaddress}), 64'd0);
    check_val({tag, "_data"}, {busdata_in, hif.host_data_out}, 64'd0);
  endtask

  task automatic wait_load_done(input string tag, input int budget);
    int base;
    base = ld_count;
    for (int k = 0; k < budget && ld_count == base; k++) tick();
    check_val(tag, 64'(ld_count != base), 64'd1);
  endtask

  task automatic wait_wr(input string tag, input int target);
    for (int k = 0; k < 500 && wr_count < target; k++) tick();
    check_val(tag, 64'(wr_count >= target), 64'd1);
  endtask

  task automatic wait_ack(input string tag, output int at);
    at = -1;
    for (int k = 0; k < 600 && at < 0; k++) begin
      tick();
      if (hif.host_ack) at = cyc;
    end
    check_val(tag, 64'(at >= 0), 64'd1);
  endtask

  task automatic host_txn(input string tag, input bit is_rd, input logic [WA-1:0] a,
                          input logic [BW-1:0] d, input int exp_lat);
    int t0;
    bit got;
    ack_t e;
    tick();
    hif.host_address = a;
    hif.host_data_in = d;
    if (is_rd) hif.host_read = 1'b1;
    else hif.host_write = 1'b1;
    t0 = cyc;
    if (!is_rd) wq.push_back({a, d});
    e.is_rd = is_rd;
    e.data = rd_value;
    aq.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      tick();
      if (cyc - t0 == 1) begin
        check_val({tag, "_strobe"}, 64'({write_reg, read_reg}), is_rd ? 64'd1 : 64'd2);
        check_val({tag, "_addr1"}, 64'(busaddress), 64'(a));
      end
      if (!is_rd && cyc - t0 >= 2 && cyc - t0 <= 1 + HOLD)
        check_val({tag, "_hold"}, 64'({write_reg, busaddress, busdata_in}), 64'({1'b0, a, d}));
      if (is_rd && cyc - t0 >= 2 && cyc - t0 <= 2 + RL)
        check_val({tag, "_hold"}, 64'({read_reg, busaddress}), 64'({1'b0, a}));
      if (hif.host_ack) got = 1'b1;
    end
    check_val({tag, "_ack_cycle"}, 64'(cyc - t0), 64'(exp_lat));
    hif.host_write = 1'b0;
    hif.host_read = 1'b0;
  endtask

  initial begin
    int rel_cyc;
    int ack_at;
    int base;
    int t0;
    hif.host_write = 1'b0;
    hif.host_read = 1'b0;
    hif.host_address = '0;
    hif.host_data_in = '0;
    for (int i = 0; i < (1 << TAW); i++)
      tbl_mem[i] = {WA'(14'h0440 + i), (32'h01010101 * i) ^ 32'h5A5A0000};
    tbl_mem[0] = {14'h0440, 32'h00FFFFFF};

    // Reset state, then the automatic load after release.
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    rel_cyc = cyc;
    wr_count = 0;
    push_table();
    wait_load_done("t1_load_done", 400);
    check_val("t1_load_cycle", 64'(ld_cyc - rel_cyc), 64'd216);
    check_val("t1_write_count", 64'(wr_count), 64'd36);
    tick();
    check_val("t1_busy_after", 64'(busy), 64'd0);
    check_val("t1_wq_empty", 64'(wq.size()), 64'd0);
    $display("t1 auto load: %0d writes, load_done at cycle %0d", wr_count, ld_cyc - rel_cyc);

    // Terminator at entry 3.
    tbl_mem[3] = {14'h3FFF, 32'h0};
    wr_count = 0;
    push_table();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_load_done("t2_load_done", 100);
    check_val("t2_write_count", 64'(wr_count), 64'd3);
    check_val("t2_done_after_last", 64'(ld_cyc - last_wr_cyc), 64'd6);
    check_val("t2_wq_empty", 64'(wq.size()), 64'd0);
    tbl_mem[3] = {WA'(14'h0440 + 3), (32'h01010101 * 3) ^ 32'h5A5A0000};
    $display("t2 terminator: %0d writes", wr_count);

    // Host write and read in IDLE.
    host_txn("t3_wr", 1'b0, 14'h0448, 32'h12345678, 6);
    $display("t3 host write 0448 <= 12345678 done");
    host_txn("t4_rd", 1'b1, 14'h0448, 32'h0, 5);
    repeat (3) tick();
    check_val("t4_rd_held", 64'(hif.host_data_out), 64'hCAFEF00D);
    $display("t4 host read 0448 -> %0h", hif.host_data_out);

    // Host write during a load, start pulse ignored mid-load.
    tick();
    wr_count = 0;
    base = ld_count;
    push_table();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_wr("t5_reach_10", 10);
    hif.host_address = 14'h0500;
    hif.host_data_in = 32'hA5A50005;
    hif.host_write = 1'b1;
    wq.push_back({14'h0500, 32'hA5A50005});
    aq.push_back('{is_rd: 1'b0, data: rd_value});
    wait_wr("t5_reach_20", 20);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_load_done("t5_load_done", 300);
    wait_ack("t5_ack_seen", ack_at);
    hif.host_write = 1'b0;
    check_val("t5_ack_after_load", 64'(ack_at - ld_cyc), 64'd7);
    repeat (300) tick();
    check_val("t5_single_load", 64'(ld_count - base), 64'd1);
    check_val("t5_write_count", 64'(wr_count), 64'd37);
    check_val("t5_wq_empty", 64'(wq.size()), 64'd0);
    $display("t5 mid-load write: ack %0d cycles after load_done", ack_at - ld_cyc);

    // Reset during H_HOLD of a host write that stays requested.
    tick();
    hif.host_address = 14'h0600;
    hif.host_data_in = 32'h600DF00D;
    hif.host_write = 1'b1;
    wq.push_back({14'h0600, 32'h600DF00D});
    t0 = cyc;
    for (int k = 0; k < 10 && cyc - t0 < 3; k++) tick();
    check_val("t6_in_hold", 64'(busy && !write_reg), 64'd1);
    rst = 1'b1;
    wq.delete();
    aq.delete();
    tick();
    check_reset_outputs("t6_reset1");
    tick();
    check_reset_outputs("t6_reset2");
    rst = 1'b0;
    rel_cyc = cyc;
    wr_count = 0;
    base = ld_count;
    push_table();
    wq.push_back({14'h0600, 32'h600DF00D});
    aq.push_back('{is_rd: 1'b0, data: rd_value});
    wait_load_done("t6_load_done", 400);
    check_val("t6_load_cycle", 64'(ld_cyc - rel_cyc), 64'd216);
    wait_ack("t6_ack_seen", ack_at);
    hif.host_write = 1'b0;
    check_val("t6_ack_after_load", 64'(ack_at - ld_cyc), 64'd7);
    repeat (5) tick();
    check_val("t6_wq_empty", 64'(wq.size()), 64'd0);
    check_val("t6_aq_empty", 64'(aq.size()), 64'd0);
    $display("t6 reset mid-write: reload then write, %0d writes", wr_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
